// File: rtl/sha256_pkg.sv
// Shared widths, FSM state encoding and block-splice helper for the sha256 nonce scheduler.
package sha256_pkg;

    localparam int unsigned BLK_W     = 512;
    localparam int unsigned HASH_W    = 256;
    localparam int unsigned NONCE_W   = 32;
    localparam int unsigned LZ_W      = 9;
    localparam int unsigned CNT_W     = NONCE_W + 1;
    localparam int unsigned BLK_IDX_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        WAIT,
        CHECK,
        DONE
    } state_e;

    // Overwrite the nonce field of a block template.
    function automatic logic [BLK_W-1:0] splice_nonce(
        input logic [BLK_W-1:0]     tmpl,
        input logic [NONCE_W-1:0]   nonce,
        input logic [BLK_IDX_W-1:0] ofs
    );
        logic [BLK_W-1:0] blk;
        blk = tmpl;
        blk[ofs +: NONCE_W] = nonce;
        return blk;
    endfunction

    // Difficulties beyond the digest width can only ever be met by 256 zeros.
    function automatic logic [LZ_W-1:0] clamp_diff(input logic [LZ_W-1:0] d);
        return (d > LZ_W'(HASH_W)) ? LZ_W'(HASH_W) : d;
    endfunction

endpackage

// File: rtl/sha256_nonce_sched_if.sv
// Block/digest bus between the nonce scheduler (master) and the sha256 core (slave).
interface sha256_nonce_sched_if;
    import sha256_pkg::*;

    logic [BLK_W-1:0]  mess_o;
    logic              padded_o;
    logic              rdy_i;
    logic [HASH_W-1:0] hash_i;

    modport master (
        output mess_o,
        output padded_o,
        input  rdy_i,
        input  hash_i
    );

    modport slave (
        input  mess_o,
        input  padded_o,
        output rdy_i,
        output hash_i
    );

endinterface

// File: rtl/sha256_lzc.sv
// Combinational leading-zero counter over a 256-bit digest, MSB first; all-zero gives 256.
module sha256_lzc
    import sha256_pkg::*;
(
    input  logic [HASH_W-1:0] hash,
    output logic [LZ_W-1:0]   count_c
);

    logic seen;

    // Scan from the MSB and keep the position of the first set bit.
    always_comb begin
        count_c = LZ_W'(HASH_W);
        seen    = 1'b0;
        for (int i = HASH_W - 1; i >= 0; i--) begin
            if (!seen && hash[i]) begin
                count_c = LZ_W'(HASH_W - 1 - i);
                seen    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha256_nonce_sched.sv
// Nonce search sequencer in front of the unrolled sha256 core.
// Optional core-ready timeout: define SHA_SCHED_TIMEOUT_EN.
module sha256_nonce_sched
    import sha256_pkg::*;
#(
    parameter int unsigned NONCE_OFS = 416,
    parameter int unsigned TIMEOUT   = 127
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [BLK_W-1:0]     template_i,
    input  logic [NONCE_W-1:0]   nonce_start_i,
    input  logic [NONCE_W-1:0]   nonce_limit_i,
    input  logic [LZ_W-1:0]      difficulty_i,
    sha256_nonce_sched_if.master core,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 found_o,
    output logic [NONCE_W-1:0]   nonce_o,
    output logic [HASH_W-1:0]    hash_o,
    output logic [CNT_W-1:0]     attempts_o,
    output logic                 err_o
);

    localparam logic [BLK_IDX_W-1:0] OFS = BLK_IDX_W'(NONCE_OFS);

    state_e             state_q, state_d;
    logic [BLK_W-1:0]   tmpl_q, tmpl_d;
    logic [BLK_W-1:0]   mess_q, mess_d;
    logic [NONCE_W-1:0] limit_q, limit_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [LZ_W-1:0]    diff_q, diff_d;
    logic [HASH_W-1:0]  hash_q, hash_d;
    logic [CNT_W-1:0]   attempts_q, attempts_d;
    logic               padded_q, padded_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               found_q, found_d;
    logic               err_q, err_d;
    logic [LZ_W-1:0]    lz_c;

`ifdef SHA_SCHED_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_hit_c;
    assign tmo_hit_c = (tmo_q >= TMO_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    sha256_lzc u_lzc (
        .hash    (hash_q),
        .count_c (lz_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next values of every registered output / datapath field.
    always_comb begin
        state_d    = state_q;
        tmpl_d     = tmpl_q;
        mess_d     = mess_q;
        limit_d    = limit_q;
        nonce_d    = nonce_q;
        diff_d     = diff_q;
        hash_d     = hash_q;
        attempts_d = attempts_q;
        padded_d   = padded_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        found_d    = found_q;
        err_d      = err_q;
`ifdef SHA_SCHED_TIMEOUT_EN
        tmo_d      = '0;
`endif

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    tmpl_d     = template_i;
                    limit_d    = nonce_limit_i;
                    diff_d     = clamp_diff(difficulty_i);
                    nonce_d    = nonce_start_i;
                    found_d    = 1'b0;
                    attempts_d = '0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    if (nonce_start_i > nonce_limit_i) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d  = LOAD;
                        mess_d   = splice_nonce(template_i, nonce_start_i, OFS);
                        padded_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_d = ARM;
            end
            ARM: begin
                // A ready still high from the previous block must drop first.
                if (!core.rdy_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (core.rdy_i) begin
                    hash_d     = core.hash_i;
                    attempts_d = attempts_q + CNT_W'(1);
                    padded_d   = 1'b0;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (lz_c >= diff_q) begin
                    found_d = 1'b1;
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (nonce_q == limit_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    nonce_d  = nonce_q + NONCE_W'(1);
                    mess_d   = splice_nonce(tmpl_q, nonce_q + NONCE_W'(1), OFS);
                    padded_d = 1'b1;
                    state_d  = LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                padded_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase

`ifdef SHA_SCHED_TIMEOUT_EN
        // Count core-wait cycles; give up once the budget is spent.
        if (state_q == ARM || state_q == WAIT) begin
            tmo_d = tmo_q + TMO_W'(1);
            if (tmo_hit_c && !(state_q == WAIT && core.rdy_i)) begin
                state_d  = DONE;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                padded_d = 1'b0;
                found_d  = 1'b0;
                err_d    = 1'b1;
            end
        end
`endif

        // Abort wins over everything else outside IDLE; results are kept.
        if (abort_i && state_q != IDLE) begin
            state_d    = IDLE;
            nonce_d    = nonce_q;
            hash_d     = hash_q;
            attempts_d = attempts_q;
            mess_d     = mess_q;
            err_d      = err_q;
            padded_d   = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            found_d    = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmpl_q     <= '0;
            mess_q     <= '0;
            limit_q    <= '0;
            nonce_q    <= '0;
            diff_q     <= '0;
            hash_q     <= '0;
            attempts_q <= '0;
            padded_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            found_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tmpl_q     <= tmpl_d;
            mess_q     <= mess_d;
            limit_q    <= limit_d;
            nonce_q    <= nonce_d;
            diff_q     <= diff_d;
            hash_q     <= hash_d;
            attempts_q <= attempts_d;
            padded_q   <= padded_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            found_q    <= found_d;
            err_q      <= err_d;
        end
    end

`ifdef SHA_SCHED_TIMEOUT_EN
    // Core-wait cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign core.mess_o   = mess_q;
    assign core.padded_o = padded_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign found_o       = found_q;
    assign nonce_o       = nonce_q;
    assign hash_o        = hash_q;
    assign attempts_o    = attempts_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_sha256_nonce_sched.sv
// Self-checking bench for sha256_nonce_sched with a behavioural core model and block scoreboard.
module tb_sha256_nonce_sched;
    import sha256_pkg::*;

    localparam int unsigned OFS = 416;
    localparam int unsigned TMO = 40;
    localparam int          LAT = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [BLK_W-1:0]    tmpl = '0;
    logic [NONCE_W-1:0]  nstart = '0;
    logic [NONCE_W-1:0]  nlimit = '0;
    logic [LZ_W-1:0]     diff = '0;
    logic                busy, done, found, err;
    logic [NONCE_W-1:0]  nonce;
    logic [HASH_W-1:0]   hash;
    logic [CNT_W-1:0]    attempts;

    int checks = 0;
    int errors = 0;
    logic [BLK_W-1:0] sb[$];
    bit pad_prev = 1'b0;

    bit model_stale = 1'b0;
    bit model_never = 1'b0;
    int mcnt = 0;
    bit mpad = 1'b0;

    always #5 clk = ~clk;

    sha256_nonce_sched_if core_if ();

    sha256_nonce_sched #(.NONCE_OFS(OFS), .TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .abort_i       (abort),
        .template_i    (tmpl),
        .nonce_start_i (nstart),
        .nonce_limit_i (nlimit),
        .difficulty_i  (diff),
        .core          (core_if),
        .busy_o        (busy),
        .done_o        (done),
        .found_o       (found),
        .nonce_o       (nonce),
        .hash_o        (hash),
        .attempts_o    (attempts),
        .err_o         (err)
    );

    // Digest only 0x1003 has a zero top byte (19 leading zeros); 0x77 hashes to all zeros.
    function automatic logic [HASH_W-1:0] digest(input logic [31:0] n);
        logic [7:0] top;
        if (n == 32'h77) return '0;
        top = (n == 32'h1003) ? 8'h00 : {1'b1, n[6:0]};
        return {top, n[23:0], {7{n ^ 32'h5A5A_5A5A}}};
    endfunction

    // Core model: ready LAT edges after padded rises; stale mode keeps the old ready briefly.
    always @(posedge clk) begin
        int c;
        if (rst || model_never) begin
            core_if.rdy_i <= 1'b0;
            mcnt <= 0;
            mpad <= 1'b0;
            if (rst) core_if.hash_i <= '0;
        end else begin
            c = (core_if.padded_o && !mpad) ? 1 : (core_if.padded_o ? mcnt + 1 : 0);
            mcnt <= c;
            mpad <= core_if.padded_o;
            if (core_if.padded_o) begin
                if (model_stale && c < 3) begin
                    core_if.rdy_i <= core_if.rdy_i;
                end else if (c < LAT) begin
                    core_if.rdy_i <= 1'b0;
                end else begin
                    core_if.rdy_i  <= 1'b1;
                    core_if.hash_i <= digest(core_if.mess_o[OFS +: 32]);
                end
            end else if (!model_stale) begin
                core_if.rdy_i <= 1'b0;
            end
        end
    end

    // One cycle; compares each newly issued block against the scoreboard.
    task automatic tick();
        logic [BLK_W-1:0] exp;
        @(posedge clk);
        #1;
        if (core_if.padded_o && !pad_prev) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_block nonce %h required none", core_if.mess_o[OFS +: 32]);
            end else begin
                exp = sb.pop_front();
                if (core_if.mess_o !== exp) begin
                    errors++;
                    $display("FAIL sb_block nonce %h required %h (full block compared)",
                             core_if.mess_o[OFS +: 32], exp[OFS +: 32]);
                end
            end
        end
        pad_prev = core_if.padded_o;
    endtask

    task automatic new_template();
        for (int i = 0; i < 16; i++) tmpl[i*32 +: 32] = $urandom();
    endtask

    task automatic push_range(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] n;
        logic [BLK_W-1:0] blk;
        for (n = {1'b0, a}; n <= {1'b0, b}; n++) begin
            blk = tmpl;
            blk[OFS +: 32] = n[31:0];
            sb.push_back(blk);
        end
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] l, input logic [8:0] d);
        nstart = s;
        nlimit = l;
        diff   = d;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < budget) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({core_if.mess_o, core_if.padded_o, busy, done, found, nonce, hash, attempts, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b padded=%b attempts=%0d required all zero",
                     busy, done, core_if.padded_o, attempts);
        end
    endtask

    task automatic test_diff0();
        int cyc; bit ok;
        new_template();
        push_range(32'd5, 32'd5);
        do_start(32'd5, 32'd9, 9'd0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL diff0_busy got %b required 1", busy); end
        wait_done(200, cyc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL diff0_timeout got no done required done"); end
        checks++;
        if ({found, attempts, nonce} !== {1'b1, 33'd1, 32'd5}) begin
            errors++;
            $display("FAIL diff0_result found=%b attempts=%0d nonce=%h required 1 1 5", found, attempts, nonce);
        end
        checks++;
        if (hash !== digest(32'd5)) begin errors++; $display("FAIL diff0_hash got %h required %h", hash, digest(32'd5)); end
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin errors++; $display("FAIL diff0_pulse done=%b busy=%b required 0 0", done, busy); end
    endtask

    task automatic test_match();
        int cyc; bit ok;
        new_template();
        push_range(32'h1000, 32'h1003);
        do_start(32'h1000, 32'h10FF, 9'd8);
        wait_done(400, cyc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL match_timeout got no done required done"); end
        checks++;
        if ({found, attempts, nonce} !== {1'b1, 33'd4, 32'h1003}) begin
            errors++;
            $display("FAIL match_result found=%b attempts=%0d nonce=%h required 1 4 1003", found, attempts, nonce);
        end
        checks++;
        if (hash !== digest(32'h1003)) begin errors++; $display("FAIL match_hash got %h required %h", hash, digest(32'h1003)); end
        tick();
    endtask

    task automatic test_lzc_edge();
        int cyc; bit ok;
        new_template();
        push_range(32'h1003, 32'h1003);
        do_start(32'h1003, 32'h1004, 9'd19);
        wait_done(200, cyc, ok);
        checks++;
        if (!ok || {found, attempts} !== {1'b1, 33'd1}) begin
            errors++;
            $display("FAIL lzc19 ok=%b found=%b attempts=%0d required 1 1 1", ok, found, attempts);
        end
        tick();
        push_range(32'h1003, 32'h1004);
        do_start(32'h1003, 32'h1004, 9'd20);
        wait_done(200, cyc, ok);
        checks++;
        if (!ok || {found, attempts, nonce} !== {1'b0, 33'd2, 32'h1004}) begin
            errors++;
            $display("FAIL lzc20 ok=%b found=%b attempts=%0d nonce=%h required 1 0 2 1004", ok, found, attempts, nonce);
        end
        tick();
    endtask

    task automatic test_clamp();
        int cyc; bit ok;
        new_template();
        push_range(32'h77, 32'h77);
        do_start(32'h77, 32'h78, 9'h1FF);
        wait_done(200, cyc, ok);
        checks++;
        if (!ok || {found, attempts, hash} !== {1'b1, 33'd1, 256'd0}) begin
            errors++;
            $display("FAIL clamp ok=%b found=%b attempts=%0d required 1 1 1 with zero digest", ok, found, attempts);
        end
        tick();
    endtask

    task automatic test_no_wrap();
        int cyc; bit ok;
        new_template();
        push_range(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        do_start(32'hFFFF_FFFE, 32'hFFFF_FFFF, 9'd256);
        wait_done(300, cyc, ok);
        checks++;
        if (!ok || {found, attempts, nonce} !== {1'b0, 33'd2, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL no_wrap ok=%b found=%b attempts=%0d nonce=%h required 1 0 2 ffffffff", ok, found, attempts, nonce);
        end
        repeat (20) tick();
    endtask

    task automatic test_empty_range();
        int cyc; bit ok;
        new_template();
        do_start(32'd10, 32'd3, 9'd0);
        wait_done(4, cyc, ok);
        checks++;
        if (!ok || cyc > 1) begin
            errors++;
            $display("FAIL empty_latency ok=%b extra_cycles=%0d required done within 2 cycles of start", ok, cyc);
        end
        checks++;
        if ({found, attempts, nonce, busy} !== {1'b0, 33'd0, 32'd10, 1'b0}) begin
            errors++;
            $display("FAIL empty_result found=%b attempts=%0d nonce=%h busy=%b required 0 0 a 0", found, attempts, nonce, busy);
        end
        repeat (6) tick();
    endtask

    task automatic test_abort();
        int cyc; int guard; bit ok; bit seen_done; bit held;
        new_template();
        model_stale = 1'b1;
        push_range(32'h20, 32'h22);
        do_start(32'h20, 32'h30, 9'd256);
        guard = 0;
        while (sb.size() != 0 && guard < 300) begin tick(); guard++; end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL abort_third_block got %0d pending required 0", sb.size()); end
        held = 1'b1;
        repeat (5) begin tick(); if (core_if.padded_o !== 1'b1) held = 1'b0; end
        checks++;
        if (!held || attempts !== 33'd2) begin
            errors++;
            $display("FAIL abort_stale_rdy padded_held=%b attempts=%0d required 1 2", held, attempts);
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if ({core_if.padded_o, busy, done, found} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_idle padded=%b busy=%b done=%b found=%b required 0 0 0 0",
                     core_if.padded_o, busy, done, found);
        end
        checks++;
        if ({attempts, nonce, hash} !== {33'd2, 32'h22, digest(32'h21)}) begin
            errors++;
            $display("FAIL abort_keep attempts=%0d nonce=%h required 2 22 with digest of 21", attempts, nonce);
        end
        seen_done = 1'b0;
        repeat (4) begin tick(); if (done || busy) seen_done = 1'b1; end
        checks++;
        if (seen_done) begin errors++; $display("FAIL abort_no_done got done/busy activity required none"); end
        model_stale = 1'b0;
        repeat (2) tick();
        push_range(32'h40, 32'h40);
        do_start(32'h40, 32'h50, 9'd0);
        wait_done(200, cyc, ok);
        checks++;
        if (!ok || {found, attempts, nonce} !== {1'b1, 33'd1, 32'h40}) begin
            errors++;
            $display("FAIL abort_restart ok=%b found=%b attempts=%0d nonce=%h required 1 1 1 40", ok, found, attempts, nonce);
        end
        tick();
    endtask

`ifdef SHA_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int cyc; bit ok;
        new_template();
        model_never = 1'b1;
        push_range(32'd0, 32'd0);
        do_start(32'd0, 32'd5, 9'd0);
        wait_done(TMO + 50, cyc, ok);
        checks++;
        if (!ok || cyc < int'(TMO) - 2 || cyc > int'(TMO) + 4) begin
            errors++;
            $display("FAIL timeout_latency ok=%b cycles=%0d required about %0d", ok, cyc, TMO);
        end
        checks++;
        if ({err, found, attempts} !== {1'b1, 1'b0, 33'd0}) begin
            errors++;
            $display("FAIL timeout_result err=%b found=%b attempts=%0d required 1 0 0", err, found, attempts);
        end
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        new_template();
        model_never = 1'b1;
        push_range(32'h99, 32'h99);
        do_start(32'h99, 32'hA0, 9'd4);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({core_if.mess_o, core_if.padded_o, busy, done, found, nonce, hash, attempts, err} !== '0) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b padded=%b nonce=%h required all zero",
                     busy, done, core_if.padded_o, nonce);
        end
        rst = 1'b0;
        model_never = 1'b0;
        repeat (3) tick();
        checks++;
        if ({busy, done, core_if.padded_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_idle busy=%b done=%b padded=%b required 0 0 0", busy, done, core_if.padded_o);
        end
    endtask

    initial begin
        test_reset();
        test_diff0();
        test_match();
        test_lzc_edge();
        test_clamp();
        test_no_wrap();
        test_empty_range();
        test_abort();
`ifdef SHA_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d blocks outstanding required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_nonce_sched.md
Name: sha256_nonce_sched

Overview:
Sequencer that drives the unrolled sha256 core through a nonce search. It takes a 512-bit padded block template and splices a 32-bit nonce into it. It then issues the block to the core, waits for the core's ready, and checks the digest for a required count of leading zero bits. It stops when a hit is found or the nonce range is exhausted; it sits between host/control logic and the sha256 core in place of the byte-wise input padder.

Parameters:
NONCE_OFS, 416, LSB bit position of the 32-bit nonce field inside the 512-bit block (nonce occupies [NONCE_OFS+31:NONCE_OFS]); legal 0..480.
TIMEOUT, 127, max cycles waiting for core ready (used only with SHA_SCHED_TIMEOUT_EN).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start_i  in  1  start search (sampled only in IDLE)
abort_i  in  1  abandon search, return to IDLE
template_i  in  512  padded block; nonce field bits ignored
nonce_start_i  in  32  first nonce
nonce_limit_i  in  32  last nonce, inclusive
difficulty_i  in  9  required leading zero bits of digest, 0..256
mess_o  out  512  block to core (template with nonce spliced)
padded_o  out  1  message-valid to core
rdy_i  in  1  core digest-ready
hash_i  in  256  core digest
busy_o  out  1  search in progress
done_o  out  1  one-cycle pulse at end of search
found_o  out  1  hit flag, valid from done_o until next start
nonce_o  out  32  winning or last tried nonce
hash_o  out  256  digest of nonce_o
attempts_o  out  33  number of blocks hashed this search
err_o  out  1  core timeout (feature only; tied 0 otherwise)

Behaviour:
- Reset: state IDLE; all outputs 0, including mess_o, padded_o, busy_o, done_o, found_o, nonce_o, hash_o, attempts_o and err_o.
- Reset asserted mid-search: IDLE next edge; padded_o low; no done_o pulse.
- On start_i in IDLE:
  - Latch template_i, nonce_limit_i and difficulty_i (difficulty >256 clamps to 256).
  - Load the nonce register with nonce_start_i.
  - Clear found_o, attempts_o and err_o; busy_o=1.
  - If nonce_start_i > nonce_limit_i, go to DONE with zero attempts; otherwise go to LOAD.
- start_i outside IDLE is ignored.
- States:
  - IDLE.
  - LOAD (1 cycle): mess_o updated with the current nonce; padded_o=1.
  - ARM: padded_o=1; wait for rdy_i==0 so a stale ready from the prior block is rejected.
  - WAIT: padded_o=1; on rdy_i==1, latch hash_i to hash_o, attempts_o+=1, go to CHECK.
  - CHECK (1 cycle): padded_o=0, guaranteeing at least one low cycle to the core between blocks.
    - If lzc(hash_o) >= difficulty: found_o=1, go to DONE.
    - Else if nonce==nonce_limit: go to DONE with found_o=0.
    - Else nonce+=1 and go to LOAD.
  - DONE (1 cycle): done_o=1, busy_o=0, then IDLE.
- mess_o is stable and padded_o held high from LOAD through WAIT; mess_o holds its value in IDLE.
- nonce_o follows the in-flight nonce and holds its final value after DONE.
- Nonce compare occurs before increment, so limit 0xFFFFFFFF never wraps; a full range gives attempts_o = 2^32.
- Leading zeros are counted from hash[255] downward; an all-zero digest yields 256.
- difficulty 0 hits on the first attempt.
- abort_i in any non-IDLE state: IDLE next edge, padded_o=0, busy_o=0, no done_o.
  - Results (nonce_o, hash_o, attempts_o) keep their last values; found_o=0.
  - abort_i has priority over rdy_i and over start_i in the same cycle.
- Minimum per-attempt overhead: 2 cycles (LOAD, CHECK) plus core latency.

Optional Feature:
SHA_SCHED_TIMEOUT_EN:
- With the macro: a cycle counter runs in ARM+WAIT and clears on LOAD.
  - Reaching TIMEOUT without a rdy_i rise sets err_o=1 and goes to DONE with found_o=0.
  - err_o holds until the next start_i.
- Without the macro: no counter; WAIT waits indefinitely; err_o tied 0.

Decomposition:
- Package sha256_pkg holds:
  - the state enum (IDLE, LOAD, ARM, WAIT, CHECK, DONE);
  - the widths BLK_W=512, HASH_W=256, NONCE_W=32 and LZ_W=9.
- Sub-module sha256_lzc: combinational 256-bit leading-zero counter with 9-bit result; instantiated once on hash_o.

Test Plan:
1. difficulty=0, start=5, limit=9 -> exactly one block issued with nonce 5; done_o pulse; found_o=1, attempts_o=1, nonce_o=5.
2. Core model returns digest with hash[255:248]=0 only for nonce 0x1003; difficulty=8, range 0x1000..0x10FF -> found_o=1, nonce_o=0x1003, attempts_o=4, hash_o equals the model digest.
3. difficulty=256 (never met), range 0xFFFFFFFE..0xFFFFFFFF -> 2 attempts, found_o=0, nonce_o=0xFFFFFFFF, no wrap to 0.
4. start=10, limit=3 -> done_o 2 cycles after start_i, attempts_o=0, padded_o never high.
5. Core model keeps rdy_i high from the previous block; assert abort_i during WAIT of the 3rd attempt -> no premature CHECK in ARM; after abort, IDLE next cycle, padded_o=0, no done_o; a following start_i restarts cleanly.
6. With SHA_SCHED_TIMEOUT_EN, core never asserts rdy_i -> err_o=1 and done_o after TIMEOUT cycles, found_o=0; reset asserted during WAIT clears all outputs on the next edge.
